// File: rtl/cla_nibble_seq.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice is reused across all
// operand nibbles, LSB first. Results are offered with a valid/ready handshake.
module cla_nibble_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 ci,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 ovf,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one nibble per cycle through the shared slice
    // DONE  | result held with out_valid high until out_ready

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry;
    logic [IW-1:0] idx;

    logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_s;
    logic       c1, c2, c3, c4;

    assign sl_a = 4'(a_r >> {idx, 2'b00});
    assign sl_b = 4'(b_r >> {idx, 2'b00});

    // The single shared 4-bit carry-lookahead slice
    always_comb begin
        sl_g = sl_a & sl_b;
        sl_p = sl_a ^ sl_b;
        c1   = sl_g[0] | (sl_p[0] & carry);
        c2   = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry);
        c3   = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
             | (sl_p[2] & sl_p[1] & sl_p[0] & carry);
        c4   = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
             | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
             | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry);
        sl_s = sl_p ^ {c3, c2, c1, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= ci;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= sl_s;
                    carry                  <= c4;
                    idx                    <= idx + IW'(1);
                    if (idx == LAST) begin
                        // sl_s[3] is the sum MSB being written this cycle
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        co        <= c4;
                        ovf       <= (a_r[W-1] == b_r[W-1]) && (sl_s[3] != a_r[W-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq: 8-nibble instance driven through a
// scoreboard queue, plus a 1-nibble instance for the minimum-width case.
module tb_cla_nibble_seq;
    localparam int N = 8;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, ci, out_valid, out_ready, co, ovf, busy;
    logic [W-1:0] a, b, sum;

    logic       s_in_valid, s_in_ready, s_ci, s_out_valid, s_out_ready, s_co, s_ovf, s_busy;
    logic [3:0] s_a, s_b, s_sum;

    cla_nibble_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .busy(busy)
    );

    cla_nibble_seq #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .ci(s_ci), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .co(s_co), .ovf(s_ovf), .busy(s_busy)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        exp_t e;
        t     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum = t[W-1:0];
        e.co  = t[W];
        e.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Runs one operation; bp>0 holds out_ready low that many cycles in DONE.
    task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input int bp, input bit scramble);
        int   n;
        exp_t e;
        logic [W-1:0] hs;
        logic hc, ho;
        @(negedge clk);
        out_ready = (bp == 0);
        a = xa; b = xb; ci = xc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", 64'(in_ready), 64'(1));
        sb.push_back(model(xa, xb, xc));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin a = '0; b = '0; ci = 1'b0; end
        chk("busy_run", 64'({busy, in_ready}), 64'(2'b10));
        // n counts rising edges including the accepting one
        n = 1;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 64'(N + 1));
        e = sb.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("co", 64'(co), 64'(e.co));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        if (bp > 0) begin
            hs = sum; hc = co; ho = ovf;
            a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk("bp_hold", {hs, hc, ho, out_valid, in_ready}, {sum, co, ovf, 1'b1, 1'b0});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("back_idle", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        chk("reset_data", 64'({sum, co, ovf}), 64'(0));
        rst = 1'b0;

        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
        op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b1);
        op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5, 1'b0);
        chk("fixed_vector", 64'(model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1)),
            64'({32'hACF1_3569, 1'b0, 1'b0}));

        // Reset in the middle of RUN
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h1234_4321; ci = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_run_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        chk("rst_run_data", 64'({sum, co, ovf}), 64'(0));
        op(32'd5, 32'd3, 1'b0, 0, 1'b0);

        // Single-nibble instance
        @(negedge clk);
        s_a = 4'hF; s_b = 4'h1; s_ci = 1'b0; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        n = 1;
        while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("n1_latency", 64'(n), 64'(2));
        chk("n1_result", 64'({s_sum, s_co, s_ovf}), 64'({4'h0, 1'b1, 1'b0}));
        @(posedge clk); #1;
        chk("n1_idle", 64'({s_in_ready, s_out_valid}), 64'(2'b10));

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
